full_subtractor_reg: RTL and testbench



---
 rtl/full_subtractor_reg.sv | 85 ++++++++
 tb/tb_full_subtractor_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/full_subtractor_reg.sv
// full_subtractor_reg
//   Ripple-borrow subtractor computing A - B - Bin over WIDTH bits, with all
//   results registered. Captures only on cycles where in_valid is high and
//   presents the result one clock later, strobed by out_valid.
//
// Parameters:
//   WIDTH        operand/difference width in bits (1..64)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid this cycle
//   A            minuend
//   B            subtrahend
//   Bin          borrow-in to bit 0
//   difference   registered (A - B - Bin) mod 2^WIDTH
//   Bout         registered borrow-out of the MSB
//   borrow_chain registered borrow-out of every bit (MSB equals Bout)
//   overflow     registered signed overflow (always 0 when WIDTH == 1)
//   out_valid    high for one cycle per captured operand set
module full_subtractor_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] difference,
    output logic             Bout,
    output logic [WIDTH-1:0] borrow_chain,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] diff_next;
    logic [WIDTH-1:0] borrow_next;
    logic             overflow_next;

    // Ripple the borrow through a local variable so each bit sees the
    // borrow of the bit below within the same evaluation.
    always_comb begin
        logic borrow_in;
        borrow_in   = Bin;
        diff_next   = '0;
        borrow_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            diff_next[i]   = A[i] ^ B[i] ^ borrow_in;
            borrow_next[i] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow_in);
            borrow_in      = borrow_next[i];
        end
    end

    // Signed overflow is the XOR of the borrows into and out of the sign bit;
    // a single-bit subtractor has no separate sign bit, so it is tied low.
    generate
        if (WIDTH >= 2) begin : g_ovf
            assign overflow_next = borrow_next[WIDTH-1] ^ borrow_next[WIDTH-2];
        end else begin : g_no_ovf
            assign overflow_next = 1'b0;
        end
    endgenerate

    // Data registers load only on in_valid, so undefined operands on idle
    // cycles never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            difference   <= '0;
            Bout         <= 1'b0;
            borrow_chain <= '0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                difference   <= diff_next;
                Bout         <= borrow_next[WIDTH-1];
                borrow_chain <= borrow_next;
                overflow     <= overflow_next;
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor_reg.sv
module tb_full_subtractor_reg;

    logic clk;
    logic rst_n;

    // WIDTH=1 instance
    logic       iv1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic [0:0] d1, bc1;
    logic       bo1, ov1, ov1_valid;

    // WIDTH=8 instance
    logic       iv8;
    logic [7:0] a8, b8;
    logic       bin8;
    logic [7:0] d8, bc8;
    logic       bo8, ov8, ov8_valid;

    int vectors;
    int miscompares;

    full_subtractor_reg #(.WIDTH(1)) u_w1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (iv1),
        .A            (a1),
        .B            (b1),
        .Bin          (bin1),
        .difference   (d1),
        .Bout         (bo1),
        .borrow_chain (bc1),
        .overflow     (ov1),
        .out_valid    (ov1_valid)
    );

    full_subtractor_reg #(.WIDTH(8)) u_w8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (iv8),
        .A            (a8),
        .B            (b8),
        .Bin          (bin8),
        .difference   (d8),
        .Bout         (bo8),
        .borrow_chain (bc8),
        .overflow     (ov8),
        .out_valid    (ov8_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] ed, input logic eb,
                          input logic [7:0] ec, input logic eo);
        check({tag, ".out_valid"}, 64'(ov8_valid), 64'(1));
        check({tag, ".difference"}, 64'(d8), 64'(ed));
        check({tag, ".Bout"}, 64'(bo8), 64'(eb));
        check({tag, ".borrow_chain"}, 64'(bc8), 64'(ec));
        check({tag, ".overflow"}, 64'(ov8), 64'(eo));
    endtask

    initial begin
        logic [7:0] exp_d1;
        logic [7:0] exp_b1;
        logic [2:0] v;
        vectors     = 0;
        miscompares = 0;
        exp_d1      = 8'b1001_0110; // bit k is difference for {A,B,Bin}=k
        exp_b1      = 8'b1000_1110; // bit k is Bout for {A,B,Bin}=k

        rst_n = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst.w1.difference", 64'(d1), 64'(0));
        check("rst.w1.out_valid", 64'(ov1_valid), 64'(0));
        check("rst.w8.difference", 64'(d8), 64'(0));
        check("rst.w8.borrow_chain", 64'(bc8), 64'(0));
        check("rst.w8.out_valid", 64'(ov8_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth-table sweep, one vector per cycle
        #4;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            iv1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
            tick();
            check($sformatf("w1.v%0d.out_valid", k), 64'(ov1_valid), 64'(1));
            check($sformatf("w1.v%0d.difference", k), 64'(d1), 64'(exp_d1[k]));
            check($sformatf("w1.v%0d.Bout", k), 64'(bo1), 64'(exp_b1[k]));
            check($sformatf("w1.v%0d.borrow_chain", k), 64'(bc1), 64'(exp_b1[k]));
            check($sformatf("w1.v%0d.overflow", k), 64'(ov1), 64'(0));
        end

        // Asynchronous reset between edges while out_valid=1, difference=1
        iv1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async.w1.difference", 64'(d1), 64'(0));
        check("async.w1.Bout", 64'(bo1), 64'(0));
        check("async.w1.borrow_chain", 64'(bc1), 64'(0));
        check("async.w1.out_valid", 64'(ov1_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #4;

        // WIDTH=8 directed vectors
        iv8 = 1'b1; a8 = 8'h05; b8 = 8'h07; bin8 = 1'b0;
        tick();
        check8("w8.05-07", 8'hFE, 1'b1, 8'hFE, 1'b0);

        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
        tick();
        check8("w8.80-01", 8'h7F, 1'b0, 8'h7F, 1'b1);

        a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1;
        tick();
        check8("w8.00-00-1", 8'hFF, 1'b1, 8'hFF, 1'b0);

        // Valid gap: 1,0,1 with X operands during the gap
        a8 = 8'h10; b8 = 8'h03; bin8 = 1'b0;
        tick();
        check8("w8.gap.first", 8'h0D, 1'b0, 8'h0F, 1'b0);

        iv8 = 1'b0; a8 = 'x; b8 = 'x; bin8 = 1'bx;
        tick();
        check("w8.gap.out_valid", 64'(ov8_valid), 64'(0));
        check("w8.gap.difference", 64'(d8), 64'(8'h0D));
        check("w8.gap.Bout", 64'(bo8), 64'(0));
        check("w8.gap.borrow_chain", 64'(bc8), 64'(8'h0F));
        check("w8.gap.overflow", 64'(ov8), 64'(0));

        iv8 = 1'b1; a8 = 8'h33; b8 = 8'h44; bin8 = 1'b1;
        tick();
        check8("w8.gap.second", 8'hEE, 1'b1, 8'hCC, 1'b0);

        iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        tick();
        check("w8.idle.out_valid", 64'(ov8_valid), 64'(0));
        check("w8.idle.difference", 64'(d8), 64'(8'hEE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
